// File: rtl/conv3x3_window_stream_if.sv
// Pixel stream, coefficient and result bundle between the resizer, the 3x3
// convolution stage and the classifier.
interface conv3x3_window_stream_if #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned OUT_W  = 12
);
    logic [DATA_W-1:0]   pixel_in;
    logic                valid_in;
    logic [9*COEF_W-1:0] coef_in;
    logic [OUT_W-1:0]    pixel_out;
    logic                valid_out;
    logic                frame_done;

    modport master (
        output pixel_in, valid_in, coef_in,
        input  pixel_out, valid_out, frame_done
    );

    modport slave (
        input  pixel_in, valid_in, coef_in,
        output pixel_out, valid_out, frame_done
    );
endinterface

// File: rtl/conv3x3_window_stream.sv
// Streaming 3x3 convolution over a padded frame: two line buffers feed a
// sliding window, then a 2-stage multiply / sum-shift-ReLU-saturate pipeline.
module conv3x3_window_stream #(
    parameter int unsigned PAD_DIM = 34,
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned COEF_W  = 8,
    parameter int unsigned OUT_W   = 12,
    parameter int unsigned SHIFT   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    conv3x3_window_stream_if.slave        bus
);
    localparam int unsigned CNT_W  = $clog2(PAD_DIM);
    localparam int unsigned PIX_W  = DATA_W + 1;
    localparam int unsigned PROD_W = PIX_W + COEF_W;
    localparam int unsigned ACC_W  = 24;
    localparam int unsigned TAPS   = 9;
    localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(PAD_DIM - 1);
    localparam logic signed [ACC_W-1:0] OUT_MAX  = ACC_W'((2 ** OUT_W) - 1);

    logic [CNT_W-1:0]         col_q, col_d;
    logic [CNT_W-1:0]         row_q, row_d;
    logic [TAPS*COEF_W-1:0]   coef_q, coef_d;
    logic [DATA_W-1:0]        lb0_q [PAD_DIM];
    logic [DATA_W-1:0]        lb1_q [PAD_DIM];
    logic [DATA_W-1:0]        win_q [3][2];
    logic [DATA_W-1:0]        win_d [3][2];
    logic [DATA_W-1:0]        col_pix [3];
    logic [DATA_W-1:0]        tap_pix [TAPS];
    logic signed [PROD_W-1:0] prod_q [TAPS];
    logic signed [PROD_W-1:0] prod_d [TAPS];
    logic                     v1_q, v1_d;
    logic                     last1_q, last1_d;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  res;
    logic [OUT_W-1:0]         pixel_out_q, pixel_out_d;
    logic                     valid_out_q, valid_out_d;
    logic                     frame_done_q, frame_done_d;

    // Newest window column: rows r-2, r-1 from the line buffers, row r live.
    always_comb begin
        col_pix[0] = lb1_q[col_q];
        col_pix[1] = lb0_q[col_q];
        col_pix[2] = bus.pixel_in;
        for (int kr = 0; kr < 3; kr++) begin
            tap_pix[kr*3 + 0] = win_q[kr][0];
            tap_pix[kr*3 + 1] = win_q[kr][1];
            tap_pix[kr*3 + 2] = col_pix[kr];
        end
    end

    // Input side: raster counters, coefficient latch, window shift, stage 1.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        coef_d  = coef_q;
        win_d   = win_q;
        v1_d    = 1'b0;
        last1_d = 1'b0;
        for (int k = 0; k < TAPS; k++) begin
            prod_d[k] = PROD_W'($signed({1'b0, tap_pix[k]}))
                      * PROD_W'($signed(coef_q[k*COEF_W +: COEF_W]));
        end
        if (bus.valid_in) begin
            if (col_q == LAST_IDX) begin
                col_d = '0;
                row_d = (row_q == LAST_IDX) ? '0 : row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
            if (row_q == '0 && col_q == '0) begin
                coef_d = bus.coef_in;
            end
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = col_pix[i];
            end
            v1_d    = (row_q >= CNT_W'(2)) && (col_q >= CNT_W'(2));
            last1_d = (row_q == LAST_IDX) && (col_q == LAST_IDX);
        end
    end

    // Stage 2: sum of products, arithmetic shift, ReLU and saturation.
    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc = acc + ACC_W'(prod_q[k]);
        end
        res          = acc >>> SHIFT;
        pixel_out_d  = pixel_out_q;
        valid_out_d  = v1_q;
        frame_done_d = v1_q & last1_q;
        if (v1_q) begin
            if (res < 0) begin
                pixel_out_d = '0;
            end else if (res > OUT_MAX) begin
                pixel_out_d = '1;
            end else begin
                pixel_out_d = res[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            coef_q       <= '0;
            v1_q         <= 1'b0;
            last1_q      <= 1'b0;
            pixel_out_q  <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= '0;
                win_q[i][1] <= '0;
            end
            for (int k = 0; k < TAPS; k++) begin
                prod_q[k] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            coef_q       <= coef_d;
            v1_q         <= v1_d;
            last1_q      <= last1_d;
            pixel_out_q  <= pixel_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
            prod_q       <= prod_d;
        end
    end

    // Line buffers are always rewritten before being read, so no reset.
    always_ff @(posedge clk) begin
        if (bus.valid_in) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= bus.pixel_in;
        end
    end

    assign bus.pixel_out  = pixel_out_q;
    assign bus.valid_out  = valid_out_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_conv3x3_window_stream.sv
// Bench for conv3x3_window_stream: two instances (SHIFT=4 and SHIFT=0) share
// the input stream and are compared against a frame-level convolution model.
module tb_conv3x3_window_stream;
    localparam int unsigned PAD  = 34;
    localparam int unsigned DW   = 12;
    localparam int unsigned CW   = 8;
    localparam int unsigned OW   = 12;
    localparam int unsigned NOUT = 1024;
    localparam int unsigned NPIX = PAD * PAD;

    typedef struct {
        int val;
        bit done;
        int cyc;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] pix;
    logic          vin;
    logic [9*CW-1:0] coef_bus;

    int   img [PAD][PAD];
    int   cur_coef [9];
    int   exp_v [2][$];
    bit   exp_done [$];
    obs_t got [2][$];
    int   in_cyc [$];
    int   cyc = 0;
    int   stray = 0;
    int   n_total = 0;
    int   n_pass = 0;

    conv3x3_window_stream_if #(.DATA_W(DW), .COEF_W(CW), .OUT_W(OW)) if4 ();
    conv3x3_window_stream_if #(.DATA_W(DW), .COEF_W(CW), .OUT_W(OW)) if0 ();

    assign if4.pixel_in = pix;
    assign if4.valid_in = vin;
    assign if4.coef_in  = coef_bus;
    assign if0.pixel_in = pix;
    assign if0.valid_in = vin;
    assign if0.coef_in  = coef_bus;

    conv3x3_window_stream #(.PAD_DIM(PAD), .DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .SHIFT(4))
        u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    conv3x3_window_stream #(.PAD_DIM(PAD), .DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .SHIFT(0))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output collector (index 0 = SHIFT 4 instance, index 1 = SHIFT 0 instance)
    always @(negedge clk) begin
        if (if4.valid_out) got[0].push_back('{val: int'(if4.pixel_out), done: if4.frame_done, cyc: cyc});
        else if (if4.frame_done) stray++;
        if (if0.valid_out) got[1].push_back('{val: int'(if0.pixel_out), done: if0.frame_done, cyc: cyc});
        else if (if0.frame_done) stray++;
    end

    function automatic logic [9*CW-1:0] pack_coef();
        logic [9*CW-1:0] v;
        for (int k = 0; k < 9; k++) v[k*CW +: CW] = CW'(cur_coef[k]);
        return v;
    endfunction

    // Reference: direct 2-D convolution of the whole padded frame
    function automatic void model_frame();
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 32; j++) begin
                int acc;
                acc = 0;
                for (int kr = 0; kr < 3; kr++)
                    for (int kc = 0; kc < 3; kc++)
                        acc += img[i+kr][j+kc] * cur_coef[kr*3+kc];
                for (int d = 0; d < 2; d++) begin
                    int r;
                    r = acc >>> ((d == 0) ? 4 : 0);
                    if (r < 0) r = 0;
                    else if (r > 4095) r = 4095;
                    exp_v[d].push_back(r);
                end
                exp_done.push_back(i == 31 && j == 31);
            end
        end
    endfunction

    function automatic void clear_all();
        for (int d = 0; d < 2; d++) begin
            got[d].delete();
            exp_v[d].delete();
        end
        exp_done.delete();
        in_cyc.delete();
    endfunction

    function automatic void fill_ramp();
        for (int r = 0; r < PAD; r++)
            for (int c = 0; c < PAD; c++) img[r][c] = (r * PAD + c) & 32'hFFF;
    endfunction

    function automatic void fill_random();
        for (int r = 0; r < PAD; r++)
            for (int c = 0; c < PAD; c++) img[r][c] = int'($urandom_range(4095));
        for (int k = 0; k < 9; k++) cur_coef[k] = int'($urandom_range(255)) - 128;
    endfunction

    function automatic void set_identity();
        for (int k = 0; k < 9; k++) cur_coef[k] = 0;
        cur_coef[4] = 16;
    endfunction

    task automatic send_frame(input int gap, input int npix, input bit scramble);
        for (int n = 0; n < npix; n++) begin
            @(posedge clk); #1;
            pix = DW'(img[n / PAD][n % PAD]);
            vin = 1'b1;
            if (n == 0 || !scramble) coef_bus = pack_coef();
            else coef_bus = 72'({$urandom(), $urandom(), $urandom()});
            if (n / PAD >= 2 && n % PAD >= 2) in_cyc.push_back(cyc);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                vin = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        vin = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total += 3;
        if (if4.valid_out !== 1'b0 || if4.pixel_out !== '0 || if4.frame_done !== 1'b0)
            $display("FAIL reset_dut4 got vo=%b po=%0d fd=%b exp 0/0/0", if4.valid_out, if4.pixel_out, if4.frame_done);
        else n_pass++;
        if (if0.valid_out !== 1'b0 || if0.pixel_out !== '0 || if0.frame_done !== 1'b0)
            $display("FAIL reset_dut0 got vo=%b po=%0d fd=%b exp 0/0/0", if0.valid_out, if0.pixel_out, if0.frame_done);
        else n_pass++;
        if (got[0].size() !== 0 || got[1].size() !== 0)
            $display("FAIL reset_no_output got %0d/%0d outputs exp 0", got[0].size(), got[1].size());
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_identity();
        clear_all();
        set_identity();
        fill_ramp();
        model_frame();
        send_frame(0, NPIX, 1'b0);
        idle(4);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (got[d].size() !== exp_v[d].size())
                $display("FAIL identity_count dut%0d got=%0d exp=%0d", d, got[d].size(), exp_v[d].size());
            else n_pass++;
            for (int n = 0; n < exp_v[d].size() && n < got[d].size(); n++) begin
                n_total++;
                if (got[d][n].val !== exp_v[d][n] || got[d][n].done !== exp_done[n])
                    $display("FAIL identity_pix dut%0d n=%0d got=%0d/%0b exp=%0d/%0b",
                             d, n, got[d][n].val, got[d][n].done, exp_v[d][n], exp_done[n]);
                else n_pass++;
            end
        end
        // Closed form for the SHIFT=4 instance: centre pixel passes straight through
        for (int n = 0; n < int'(NOUT) && n < got[0].size(); n++) begin
            int e;
            e = (((n / 32) + 1) * 34 + (n % 32) + 1) & 32'hFFF;
            n_total++;
            if (got[0][n].val !== e)
                $display("FAIL identity_formula n=%0d got=%0d exp=%0d", n, got[0][n].val, e);
            else n_pass++;
        end
    endtask

    task automatic test_kernels();
        int k_tap [4] = '{1, 127, -1, -1};
        int k_c4  [4] = '{1, 127, -1, 16};
        int k_pix [4] = '{100, 4095, 50, 10};
        int k_e4  [4] = '{56, 4095, 0, 5};
        int k_e0  [4] = '{900, 4095, 0, 80};
        for (int t = 0; t < 4; t++) begin
            clear_all();
            for (int k = 0; k < 9; k++) cur_coef[k] = k_tap[t];
            cur_coef[4] = k_c4[t];
            for (int r = 0; r < PAD; r++)
                for (int c = 0; c < PAD; c++) img[r][c] = k_pix[t];
            model_frame();
            send_frame(0, NPIX, 1'b0);
            idle(4);
            for (int d = 0; d < 2; d++) begin
                int ec;
                ec = (d == 0) ? k_e4[t] : k_e0[t];
                n_total++;
                if (got[d].size() !== exp_v[d].size())
                    $display("FAIL kernel%0d_count dut%0d got=%0d exp=%0d", t, d, got[d].size(), exp_v[d].size());
                else n_pass++;
                for (int n = 0; n < exp_v[d].size() && n < got[d].size(); n++) begin
                    n_total++;
                    if (got[d][n].val !== exp_v[d][n] || got[d][n].val !== ec || got[d][n].done !== exp_done[n])
                        $display("FAIL kernel%0d_pix dut%0d n=%0d got=%0d/%0b exp=%0d/%0b",
                                 t, d, n, got[d][n].val, got[d][n].done, ec, exp_done[n]);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_gapped();
        clear_all();
        set_identity();
        fill_ramp();
        model_frame();
        send_frame(2, NPIX, 1'b0);
        idle(4);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (got[d].size() !== exp_v[d].size())
                $display("FAIL gapped_count dut%0d got=%0d exp=%0d", d, got[d].size(), exp_v[d].size());
            else n_pass++;
            for (int n = 0; n < exp_v[d].size() && n < got[d].size(); n++) begin
                n_total++;
                if (got[d][n].val !== exp_v[d][n] || got[d][n].done !== exp_done[n] ||
                    got[d][n].cyc !== in_cyc[n] + 2)
                    $display("FAIL gapped_pix dut%0d n=%0d got=%0d/%0b@%0d exp=%0d/%0b@%0d",
                             d, n, got[d][n].val, got[d][n].done, got[d][n].cyc,
                             exp_v[d][n], exp_done[n], in_cyc[n] + 2);
                else n_pass++;
            end
        end
    endtask

    task automatic test_midframe_reset();
        clear_all();
        fill_random();
        send_frame(0, 500, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        vin = 1'b0;
        @(negedge clk);
        n_total += 2;
        if (if4.valid_out !== 1'b0 || if4.frame_done !== 1'b0)
            $display("FAIL midreset_drop dut4 got vo=%b fd=%b exp 0/0", if4.valid_out, if4.frame_done);
        else n_pass++;
        if (if0.valid_out !== 1'b0 || if0.frame_done !== 1'b0)
            $display("FAIL midreset_drop dut0 got vo=%b fd=%b exp 0/0", if0.valid_out, if0.frame_done);
        else n_pass++;
        clear_all();
        @(posedge clk); #1;
        rst_n = 1'b1;
        fill_random();
        model_frame();
        send_frame(0, NPIX, 1'b0);
        idle(4);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (got[d].size() !== int'(NOUT))
                $display("FAIL midreset_count dut%0d got=%0d exp=%0d", d, got[d].size(), NOUT);
            else n_pass++;
            for (int n = 0; n < exp_v[d].size() && n < got[d].size(); n++) begin
                n_total++;
                if (got[d][n].val !== exp_v[d][n] || got[d][n].done !== exp_done[n])
                    $display("FAIL midreset_pix dut%0d n=%0d got=%0d/%0b exp=%0d/%0b",
                             d, n, got[d][n].val, got[d][n].done, exp_v[d][n], exp_done[n]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_all();
        fill_random();
        model_frame();
        send_frame(0, NPIX, 1'b1);
        fill_random();
        model_frame();
        send_frame(0, NPIX, 1'b1);
        idle(4);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (got[d].size() !== exp_v[d].size())
                $display("FAIL b2b_count dut%0d got=%0d exp=%0d", d, got[d].size(), exp_v[d].size());
            else n_pass++;
            for (int n = 0; n < exp_v[d].size() && n < got[d].size(); n++) begin
                n_total++;
                if (got[d][n].val !== exp_v[d][n] || got[d][n].done !== exp_done[n] ||
                    got[d][n].cyc !== in_cyc[n] + 2)
                    $display("FAIL b2b_pix dut%0d n=%0d got=%0d/%0b@%0d exp=%0d/%0b@%0d",
                             d, n, got[d][n].val, got[d][n].done, got[d][n].cyc,
                             exp_v[d][n], exp_done[n], in_cyc[n] + 2);
                else n_pass++;
            end
        end
    endtask

    initial begin
        pix = '0;
        vin = 1'b0;
        coef_bus = '0;
        test_reset();
        test_identity();
        test_kernels();
        test_gapped();
        test_midframe_reset();
        test_back_to_back();
        n_total++;
        if (stray !== 0) $display("FAIL stray_frame_done got=%0d exp=0", stray);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
